// File: rtl/area_ret_pkg.sv
// Shared types and widths for the area/right-triangle sequencer.
package area_ret_pkg;

    localparam int unsigned DefaultN = 16;

    localparam int unsigned SQ_W   = 2 * DefaultN + 1;
    localparam int unsigned PROD_W = 2 * DefaultN;
    localparam int unsigned AREA_W = 2 * DefaultN - 1;

    typedef enum logic [2:0] {
        StIdle,
        StSort,
        StSqMax,
        StSqL1,
        StSqL2,
        StArea,
        StCmp,
        StDone
    } state_e;

endpackage

// File: rtl/area_ret_mul.sv
// Combinational N x N -> 2N unsigned multiplier, shared across sequencer states.
module area_ret_mul #(
    parameter int unsigned N = 16
) (
    input  logic [N-1:0]   op_a,
    input  logic [N-1:0]   op_b,
    output logic [2*N-1:0] prod
);

    assign prod = {{N{1'b0}}, op_a} * {{N{1'b0}}, op_b};

endmodule

// File: rtl/area_ret_seq.sv
// Multi-cycle right-triangle check and leg-area sequencer on one shared multiplier.
// Define AREA_RET_ROUND_EN to round the halved leg product half up instead of truncating.
module area_ret_seq
    import area_ret_pkg::*;
#(
    parameter int unsigned N = DefaultN
) (
    input  logic           clock,
    input  logic           reset_,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic [N-1:0]   c,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           ret,
    output logic [2*N-2:0] area
);

    localparam int unsigned SqW   = 2 * N + 1;
    localparam int unsigned ProdW = 2 * N;
    localparam int unsigned AreaW = 2 * N - 1;

    state_e state_q;

    logic [N-1:0]     a_q, b_q, c_q;
    logic [N-1:0]     max_q, l1_q, l2_q;
    logic [SqW-1:0]   sq_max_q, sq_l1_q, sq_l2_q;
    logic [ProdW-1:0] prod_q;

    logic [N-1:0]     sel_max, sel_l1, sel_l2;
    logic [N-1:0]     op_a, op_b;
    logic [ProdW-1:0] mul_res;
    logic [SqW-1:0]   leg_sum;
    logic [ProdW-1:0] prod_rnd;
    logic             ret_next;
    logic [AreaW-1:0] area_next;

    // Ties fall toward the earlier operand, so a=b=c picks a.
    always_comb begin
        sel_max = a_q;
        sel_l1  = b_q;
        sel_l2  = c_q;
        if (c_q > a_q && c_q > b_q) begin
            sel_max = c_q;
            sel_l1  = a_q;
            sel_l2  = b_q;
        end else if (b_q > a_q) begin
            sel_max = b_q;
            sel_l1  = a_q;
            sel_l2  = c_q;
        end
    end

    always_comb begin
        op_a = l1_q;
        op_b = l2_q;
        case (state_q)
            StSqMax: begin
                op_a = max_q;
                op_b = max_q;
            end
            StSqL1: begin
                op_a = l1_q;
                op_b = l1_q;
            end
            StSqL2: begin
                op_a = l2_q;
                op_b = l2_q;
            end
            default: ;
        endcase
    end

    area_ret_mul #(
        .N(N)
    ) u_mul (
        .op_a(op_a),
        .op_b(op_b),
        .prod(mul_res)
    );

    // Each square is below 2^2N, so the SqW-bit sum cannot wrap.
    always_comb begin
        leg_sum  = sq_l1_q + sq_l2_q;
        ret_next = (sq_max_q == leg_sum) && (a_q != '0) && (b_q != '0) && (c_q != '0);
`ifdef AREA_RET_ROUND_EN
        prod_rnd = prod_q + ProdW'(1);
`else
        prod_rnd = prod_q;
`endif
        area_next = AreaW'(prod_rnd >> 1);
    end

    always_ff @(posedge clock) begin
        if (!reset_) begin
            state_q   <= StIdle;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            ret       <= 1'b0;
            area      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            max_q     <= '0;
            l1_q      <= '0;
            l2_q      <= '0;
            sq_max_q  <= '0;
            sq_l1_q   <= '0;
            sq_l2_q   <= '0;
            prod_q    <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        c_q      <= c;
                        in_ready <= 1'b0;
                        state_q  <= StSort;
                    end
                end
                StSort: begin
                    max_q   <= sel_max;
                    l1_q    <= sel_l1;
                    l2_q    <= sel_l2;
                    state_q <= StSqMax;
                end
                StSqMax: begin
                    sq_max_q <= {1'b0, mul_res};
                    state_q  <= StSqL1;
                end
                StSqL1: begin
                    sq_l1_q <= {1'b0, mul_res};
                    state_q <= StSqL2;
                end
                StSqL2: begin
                    sq_l2_q <= {1'b0, mul_res};
                    state_q <= StArea;
                end
                StArea: begin
                    prod_q  <= mul_res;
                    state_q <= StCmp;
                end
                StCmp: begin
                    ret       <= ret_next;
                    area      <= area_next;
                    out_valid <= 1'b1;
                    state_q   <= StDone;
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_area_ret_seq.sv
// Randomized self-checking bench for area_ret_seq against an arithmetic reference model.
module tb_area_ret_seq;

    localparam int unsigned N = 16;

    logic           clock;
    logic           reset_;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   a, b, c;
    logic           out_valid;
    logic           out_ready;
    logic           ret;
    logic [2*N-2:0] area;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    area_ret_seq #(
        .N(N)
    ) dut (
        .clock    (clock),
        .reset_   (reset_),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .c        (c),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .ret      (ret),
        .area     (area)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        else
            n_pass++;
    endtask

    // Right triangle iff twice the largest square equals the sum of all three squares;
    // the leg product is the full product divided by the largest side.
    task automatic model(input longint unsigned x, input longint unsigned y,
                         input longint unsigned z, output logic exp_ret,
                         output logic [63:0] exp_area);
        longint unsigned mx, prod;
        mx = x;
        if (y > mx) mx = y;
        if (z > mx) mx = z;
        prod = (mx == 0) ? 0 : (x * y * z) / mx;
        exp_ret = (x != 0) && (y != 0) && (z != 0) && (2 * mx * mx == x * x + y * y + z * z);
`ifdef AREA_RET_ROUND_EN
        prod = prod + 1;
`endif
        exp_area = prod >> 1;
    endtask

    // Called #1 after a rising edge with the DUT idle.
    task automatic run_txn(input int unsigned ta, input int unsigned tb_v, input int unsigned tc,
                           input int unsigned stall);
        logic        exp_ret;
        logic [63:0] exp_area;
        model(ta, tb_v, tc, exp_ret, exp_area);
        check("in_ready_idle", in_ready, 1);
        a        = N'(ta);
        b        = N'(tb_v);
        c        = N'(tc);
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        a        = N'($urandom);
        b        = N'($urandom);
        c        = N'($urandom);
        for (int k = 0; k < 6; k++) begin
            check("busy_in_ready", in_ready, 0);
            check("early_out_valid", out_valid, 0);
            @(posedge clock);
            #1;
        end
        check("out_valid_latency", out_valid, 1);
        check("ret", ret, exp_ret);
        check("area", area, exp_area);
        out_ready = 1'b0;
        for (int s = 0; s < int'(stall); s++) begin
            in_valid = 1'b1;
            a        = N'($urandom);
            b        = N'($urandom);
            c        = N'($urandom);
            @(posedge clock);
            #1;
            check("stall_out_valid", out_valid, 1);
            check("stall_ret", ret, exp_ret);
            check("stall_area", area, exp_area);
            check("stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        check("handoff_out_valid", out_valid, 0);
        check("handoff_in_ready", in_ready, 1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    int unsigned triples [5][3] = '{'{3, 4, 5}, '{5, 12, 13}, '{8, 15, 17},
                                     '{7, 24, 25}, '{20, 21, 29}};

    initial begin
        int unsigned x, y, z, k, sc, rot;
        reset_    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        c         = '0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_ret", ret, 0);
        check("reset_area", area, 0);
        reset_ = 1'b1;

        run_txn(3, 4, 5, 0);
        run_txn(13, 5, 12, 1);
        run_txn(7, 7, 7, 0);
        run_txn(3, 5, 7, 2);
        run_txn(0, 0, 0, 0);
        run_txn(65535, 65535, 65535, 0);
        run_txn(6, 8, 10, 10);

        // Abort a computation while it is in the leg-square phase.
        check("pre_abort_in_ready", in_ready, 1);
        a        = 16'd3;
        b        = 16'd4;
        c        = 16'd5;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        reset_ = 1'b0;
        @(posedge clock);
        #1;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_ret", ret, 0);
        check("abort_area", area, 0);
        reset_ = 1'b1;
        repeat (7) begin
            @(posedge clock);
            #1;
            check("abort_no_result", out_valid, 0);
        end
        run_txn(8, 15, 17, 0);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0: begin
                    x = $urandom_range(0, 15);
                    y = $urandom_range(0, 15);
                    z = $urandom_range(0, 15);
                end
                1: begin
                    x = $urandom_range(0, 65535);
                    y = $urandom_range(0, 65535);
                    z = $urandom_range(0, 65535);
                end
                default: begin
                    k   = $urandom_range(0, 4);
                    sc  = $urandom_range(1, 1000);
                    rot = $urandom_range(0, 2);
                    x   = triples[k][rot] * sc;
                    y   = triples[k][(rot + 1) % 3] * sc;
                    z   = triples[k][(rot + 2) % 3] * sc;
                end
            endcase
            run_txn(x, y, z, $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
